apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator: turns single-outstanding requests from a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Returns read data and error status on a one-cycle response pulse.
- Drives peripheral register interfaces such as the UART block, and provides the requester side of the APB slave interfaces.
- Adds a programmable wait-state timeout so a hung slave cannot stall the bus.

Parameters:
ADDR_W, 32, width of cmd_addr/PADDR
DATA_W, 32, width of write/read data
TIMEOUT_CYC, 256, max ACCESS cycles with PREADY low before abort; 0 disables timeout
CNT_W, 9, wait counter width; must hold TIMEOUT_CYC

Ports:
PCLK  in  1  single clock, all logic on rising edge
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  request present
cmd_ready  out  1  request accepted when valid&ready at PCLK edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data; 0 for writes/timeouts
rsp_err  out  1  PSLVERR or timeout
rsp_timeout  out  1  completion caused by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Reset (async, PRESET=1): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0; rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; wait counter = 0.
- Reset mid-transfer aborts immediately; no rsp_valid is emitted.
- All APB and rsp outputs are registered. cmd_ready = (state==IDLE), combinational from state only, independent of cmd_valid.
- IDLE:
  - cmd_ready=1, PSEL=0, PENABLE=0.
  - On cmd_valid, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, set PSEL=1, go to SETUP.
  - Between transfers, PADDR/PWRITE/PWDATA hold their last values.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0. PREADY is ignored. Next state ACCESS with PENABLE=1.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable for the whole transfer.
  - PREADY=1 at an edge: complete. Next cycle: rsp_valid=1; rsp_rdata=PRDATA for reads, 0 for writes; rsp_err=PSLVERR; rsp_timeout=0. PSEL=0, PENABLE=0, state IDLE.
  - PREADY=0: increment wait counter. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 at that edge, abort. Next cycle: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. PSEL=0, PENABLE=0, state IDLE.
  - PREADY=1 on the same edge as the timeout threshold: PREADY wins; normal completion.
  - Counter clears on entry to SETUP.
- PSLVERR is sampled only when PSEL&PENABLE&PREADY. PRDATA is sampled only on read completion.
- rsp_valid is high for exactly one cycle, with no backpressure. rsp_rdata/rsp_err/rsp_timeout hold until the next completion.
- Latency with zero wait states: handshake at edge T; SETUP in cycle T..T+1; ACCESS T+1..T+2; rsp_valid and cmd_ready high in T+2..T+3. Peak throughput is one transfer per 3 cycles. Each PREADY-low cycle adds 1.
- cmd_valid while not IDLE is not accepted; the requester holds the request. A request is accepted the same cycle rsp_valid pulses.

Decomposition:
- Package apb_pkg:
  - apb_state_e {IDLE, SETUP, ACCESS}
  - default ADDR_W/DATA_W constants
  - response struct {rdata, err, timeout}
- One natural sub-module, apb_wait_timer. Inputs: clear, count-enable, TIMEOUT_CYC. Output: expire pulse. Disabled when TIMEOUT_CYC=0.
- FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write 0x0000_0004 / 0xA5A5_0001, PREADY=1 always -> PSEL at T+1, PENABLE at T+2, PWRITE=1, PADDR/PWDATA stable through both phases; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read 0x0000_0010 with slave inserting 3 wait states, PRDATA=0x0000_00C3 -> ACCESS lasts 4 cycles; rsp_valid once with rsp_rdata=0x0000_00C3; cmd_ready low throughout.
- Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0; the next transfer completes cleanly with rsp_err=0.
- TIMEOUT_CYC=8, PREADY stuck 0 -> abort after 8 ACCESS cycles; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL drops; the next command is accepted.
- PRESET asserted during ACCESS of a write -> all outputs 0 asynchronously, no rsp_valid; after release, a read of 0x08 completes normally.
- Back-to-back: cmd_valid held with 4 queued commands, zero wait states -> accepted every 3 cycles; 4 rsp_valid pulses in order; PENABLE never high without a preceding SETUP cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts PREADY-low ACCESS cycles; pulses expire on the cycle that reaches the limit.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_clear,
  input  logic i_cnt_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)        r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_cnt_en) r_cnt <= r_cnt + 1'b1;
  end

  // A zero limit disables the abort entirely.
  assign o_expire = (TIMEOUT_CYC != 0) && i_cnt_en && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB initiator with wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        r_state, w_state_nxt;
  logic              r_psel, r_penable, r_pwrite, r_rsp_valid;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  apb_rsp_t          r_rsp, w_rsp_nxt;
  logic              w_accept, w_done, w_wait, w_expire, w_rsp_fire;
  logic              w_psel_nxt, w_penable_nxt;

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_done   = (r_state == ACCESS) && PREADY;
  assign w_wait   = (r_state == ACCESS) && !PREADY;

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timer (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .i_clear  (w_accept),
    .i_cnt_en (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (PREADY || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // PREADY wins over a coincident timeout because expire requires PREADY low.
  always_comb begin
    w_psel_nxt        = (w_state_nxt != IDLE);
    w_penable_nxt     = (w_state_nxt == ACCESS);
    w_rsp_fire        = w_done || w_expire;
    w_rsp_nxt.rdata   = (w_done && !r_pwrite) ? APB_DATA_W'(PRDATA) : '0;
    w_rsp_nxt.err     = w_done ? PSLVERR : 1'b1;
    w_rsp_nxt.timeout = !w_done;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) r_rsp <= w_rsp_nxt;
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = DATA_W'(r_rsp.rdata);
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench: reactive APB slave, protocol monitor, directed command sequences.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(9)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: ready after sl_waits low cycles in ACCESS, or never when stuck.
  int            sl_waits = 0;
  logic          sl_stuck = 1'b0;
  logic          sl_err   = 1'b0;
  logic [DW-1:0] sl_rdata = '0;

  initial begin
    int acc;
    acc = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !PRESET) begin
        acc++;
        PREADY  = !sl_stuck && (acc > sl_waits);
        PSLVERR = sl_err;
        PRDATA  = PREADY ? sl_rdata : 32'hDEAD_BEEF;
      end else begin
        acc = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hDEAD_BEEF;
      end
    end
  end

  // Protocol monitor and scoreboard consumer.
  initial begin
    logic          prev_psel, prev_pen, prev_rsp, prev_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wd;
    int            macc;
    exp_t          e;
    prev_psel = 0; prev_pen = 0; prev_rsp = 0; prev_wr = 0; prev_addr = '0; prev_wd = '0; macc = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_psel = 0; prev_pen = 0; prev_rsp = 0; macc = 0;
      end else begin
        chk("cmd_ready_vs_psel", cmd_ready, !PSEL);
        if (prev_psel && !prev_pen) chk("access_after_setup", PENABLE, 1'b1);
        if (PENABLE) begin
          chk("penable_needs_psel", PSEL, 1'b1);
          if (!prev_pen) chk("setup_before_access", prev_psel, 1'b1);
          macc++;
        end
        if (PSEL && prev_psel) begin
          chk("paddr_stable", PADDR, prev_addr);
          chk("pwdata_stable", PWDATA, prev_wd);
          chk("pwrite_stable", PWRITE, prev_wr);
        end
        if (rsp_valid) begin
          chk("rsp_one_cycle", prev_rsp, 1'b0);
          if (sb.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
          else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.to);
            chk("access_cycles", 64'(macc), 64'(e.acc));
          end
          macc = 0;
        end
        prev_psel = PSEL; prev_pen = PENABLE; prev_rsp = rsp_valid;
        prev_addr = PADDR; prev_wd = PWDATA; prev_wr = PWRITE;
      end
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] erd, input logic eerr, input logic eto,
                      input int eacc, output int t_acc);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin @(negedge PCLK); n++; end
    chk("accept_bound", cmd_ready, 1'b1);
    e.rdata = erd; e.err = eerr; e.to = eto; e.acc = eacc;
    sb.push_back(e);
    @(posedge PCLK);
    t_acc = int'($time / 10);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 300) begin @(negedge PCLK); n++; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[4];
    int tx;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, '0);
    chk("rst_pwdata", PWDATA, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_ready", cmd_ready, 1'b1);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero-wait write with phase-by-phase checks.
    sl_waits = 0;
    send(1'b1, 32'h4, 32'hA5A5_0001, '0, 1'b0, 1'b0, 1, tx);
    @(negedge PCLK);
    chk("wr_setup_psel", {PSEL, PENABLE}, 2'b10);
    chk("wr_setup_pwrite", PWRITE, 1'b1);
    chk("wr_setup_paddr", PADDR, 32'h4);
    chk("wr_setup_pwdata", PWDATA, 32'hA5A5_0001);
    @(negedge PCLK);
    chk("wr_access", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_idle", {PSEL, PENABLE}, 2'b00);
    drain();

    // Read with three wait states; data must hold after the pulse.
    sl_waits = 3; sl_rdata = 32'h0000_00C3;
    send(1'b0, 32'h10, '0, 32'hC3, 1'b0, 1'b0, 4, tx);
    drain();
    repeat (3) @(negedge PCLK);
    chk("rdata_hold", rsp_rdata, 32'hC3);
    chk("rsp_low_after", rsp_valid, 1'b0);

    // Slave error, then a clean read.
    sl_waits = 1; sl_err = 1'b1; sl_rdata = 32'h5A;
    send(1'b0, 32'h14, '0, 32'h5A, 1'b1, 1'b0, 2, tx);
    drain();
    sl_err = 1'b0; sl_rdata = 32'h77;
    send(1'b0, 32'h18, '0, 32'h77, 1'b0, 1'b0, 2, tx);
    drain();

    // Hung slave hits the timeout; next command still goes through.
    sl_stuck = 1'b1;
    send(1'b0, 32'h20, '0, '0, 1'b1, 1'b1, TO, tx);
    drain();
    chk("to_psel_drop", PSEL, 1'b0);
    sl_stuck = 1'b0; sl_waits = 0;
    send(1'b1, 32'h24, 32'h1234_5678, '0, 1'b0, 1'b0, 1, tx);
    drain();

    // Reset in the middle of a write ACCESS.
    sl_waits = 5;
    send(1'b1, 32'h30, 32'hCAFE_F00D, '0, 1'b0, 1'b0, 6, tx);
    @(negedge PCLK); @(negedge PCLK);
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("arst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("arst_paddr", PADDR, '0);
    chk("arst_pwdata", PWDATA, '0);
    chk("arst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("arst_ready", cmd_ready, 1'b1);
    void'(sb.pop_back());
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("arst_no_rsp", rsp_valid, 1'b0);
    sl_waits = 0; sl_rdata = 32'h0000_0808;
    send(1'b0, 32'h08, '0, 32'h808, 1'b0, 1'b0, 1, tx);
    drain();

    // Back-to-back: one accept every 3 cycles.
    sl_rdata = 32'h0BAD_F00D;
    send(1'b1, 32'h40, 32'h1111_1111, '0, 1'b0, 1'b0, 1, t[0]);
    send(1'b0, 32'h44, '0, 32'h0BAD_F00D, 1'b0, 1'b0, 1, t[1]);
    send(1'b1, 32'h48, 32'h3333_3333, '0, 1'b0, 1'b0, 1, t[2]);
    send(1'b0, 32'h4C, '0, 32'h0BAD_F00D, 1'b0, 1'b0, 1, t[3]);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(t[i] - t[i-1]), 64'd3);
    drain();

    repeat (3) @(negedge PCLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
